noter_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one N-bit inverter datapath (`noter`) among R requesters. Each requester presents an operand with a request. The block grants one requester at a time, passes its operand through a single internal `noter` instance, and registers the inverted result with a valid/ready output handshake. It sits between several operand producers and one result consumer, replacing per-requester inverter copies.

---
 rtl/noter_arbiter.sv | 128 ++++++++++++
 tb/tb_noter_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noter_arbiter.sv
// noter_arbiter: round-robin arbiter sharing one N-bit inverter (noter)
// among R requesters, with a registered valid/ready result stage.
//
// Ports:
//   clk         - clock; all state updates on its rising edge
//   rst_n       - asynchronous active-low reset
//   req[R]      - per-requester request, held until gnt
//   in_data     - flattened operands, requester i at [i*N +: N]
//   gnt[R]      - one-hot accept pulse (combinational)
//   out_valid   - result register holds an unconsumed result
//   out_ready   - consumer accepts the result this cycle
//   out_data[N] - registered ~operand of the winning requester
//   out_id[IW]  - index of the requester that produced out_data
//   done_count  - 16-bit completed-transfer counter
//                 (only when NOTER_ARB_COUNT_EN is defined)
//
// Optional feature macro: NOTER_ARB_COUNT_EN

module noter #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);
    assign y = ~a;
endmodule

// state | meaning
// IDLE  | no result held, out_valid=0, grant whenever any req
// HOLD  | result held, out_valid=1, next grant only with out_ready
module noter_arbiter #(
    parameter int N = 8,
    parameter int R = 4,
    localparam int IW = (R > 1) ? $clog2(R) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] in_data,
    output logic [R-1:0]   gnt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic [IW-1:0]  out_id
`ifdef NOTER_ARB_COUNT_EN
    ,
    output logic [15:0]    done_count
`endif
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] ptr_nxt;
    logic          found;
    logic          ge;
    logic          grant;
    logic [N-1:0]  op;
    logic [N-1:0] res;

    // First asserted request scanning from ptr, wrapping modulo R.
    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(ptr) + k) % R;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign ptr_nxt = (win == IW'(R - 1)) ? '0 : win + 1'b1;

    // A held result must be consumed before the next operand is accepted;
    // gating with rst_n keeps gnt low while reset is asserted.
    assign ge    = (state == IDLE) | ((state == HOLD) & out_ready);
    assign grant = ge & found & rst_n;

    always_comb begin
        gnt = '0;
        if (grant) gnt[win] = 1'b1;
    end

    assign op = in_data[int'(win)*N +: N];

    noter #(.N(N)) u_noter (
        .a (op),
        .y (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else begin
            if (grant) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                out_data  <= res;
                out_id    <= win;
                ptr       <= ptr_nxt;
            end else if (state == HOLD && out_ready) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NOTER_ARB_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_count <= '0;
        end else if (out_valid && out_ready) begin
            done_count <= done_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noter_arbiter.sv
module tb_noter_arbiter;
    localparam int N  = 8;
    localparam int R  = 4;
    localparam int IW = 2;

    logic           clk;
    logic           rst_n;
    logic [R-1:0]   req;
    logic [R*N-1:0] in_data;
    logic [R-1:0]   gnt;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic [IW-1:0]  out_id;
`ifdef NOTER_ARB_COUNT_EN
    logic [15:0]    done_count;
`endif

    int vectors;
    int miscompares;

    logic [N-1:0] d [R];

    noter_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef NOTER_ARB_COUNT_EN
        ,
        .done_count(done_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_data();
        d[0] = 8'h3C; d[1] = 8'hA5; d[2] = 8'h0F; d[3] = 8'h81;
        for (int i = 0; i < R; i++) in_data[i*N +: N] = d[i];
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        in_data   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load_data();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0 || gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_idle: valid=%b data=%h id=%0d gnt=%b, want 0 00 0 0000",
                     out_valid, out_data, out_id, gnt);
        end
        // put a result in HOLD
        req = 4'b0001;
        #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_gnt: gnt=%b, want 0001", gnt);
        end
        tick();
        req = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_hold: valid=%b data=%h id=%0d, want 1 c3 0", out_valid, out_data, out_id);
        end
        // asynchronous reset mid-HOLD, requests pending
        req = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0 || gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_async: valid=%b data=%h id=%0d gnt=%b, want 0 00 0 0000",
                     out_valid, out_data, out_id, gnt);
        end
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        in_data[2*N +: N] = 8'hA5;
        req = 4'b0100;
        #1;
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_after_gnt: gnt=%b, want 0100", gnt);
        end
        tick();
        req = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_id !== 2'd2) begin
            miscompares++;
            $display("FAIL reset_after_data: valid=%b data=%h id=%0d, want 1 5a 2", out_valid, out_data, out_id);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            vectors++;
            if (gnt !== (4'b0001 << (c % 4))) begin
                miscompares++;
                $display("FAIL fair_gnt[%0d]: gnt=%b, want %b", c, gnt, 4'b0001 << (c % 4));
            end
            if (c > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || out_id !== 2'((c - 1) % 4) || out_data !== ~d[(c - 1) % 4]) begin
                    miscompares++;
                    $display("FAIL fair_out[%0d]: valid=%b id=%0d data=%h, want 1 %0d %h",
                             c, out_valid, out_id, out_data, (c - 1) % 4, ~d[(c - 1) % 4]);
                end
            end
            tick();
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req       = 4'b0011;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL bp_first_gnt: gnt=%b, want 0001", gnt);
        end
        tick();
        req       = 4'b0010;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (gnt !== 4'b0000 || out_valid !== 1'b1 || out_data !== ~d[0] || out_id !== 2'd0) begin
                miscompares++;
                $display("FAIL bp_stall[%0d]: gnt=%b valid=%b data=%h id=%0d, want 0000 1 %h 0",
                         c, gnt, out_valid, out_data, out_id, ~d[0]);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_resume_gnt: gnt=%b, want 0010", gnt);
        end
        tick();
        req = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== ~d[1]) begin
            miscompares++;
            $display("FAIL bp_resume_out: valid=%b id=%0d data=%h, want 1 1 %h", out_valid, out_id, out_data, ~d[1]);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        req = 4'b1000;
        tick();
        req = 4'b1001;
        #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL wrap_gnt: gnt=%b, want 0001", gnt);
        end
        tick();
        vectors++;
        if (out_id !== 2'd0 || out_data !== ~d[0]) begin
            miscompares++;
            $display("FAIL wrap_out: id=%0d data=%h, want 0 %h", out_id, out_data, ~d[0]);
        end
        // ptr must now be 1: from 1 the scan of 1011 picks requester 1
        req = 4'b1011;
        #1;
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL wrap_ptr: gnt=%b, want 0010", gnt);
        end
        tick();
        req = 4'b0000;
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        out_ready = 1'b1;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== ~d[2]) begin
            miscompares++;
            $display("FAIL drain_hold: valid=%b id=%0d data=%h, want 1 2 %h", out_valid, out_id, out_data, ~d[2]);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b0 || gnt !== 4'b0000 || out_id !== 2'd2 || out_data !== ~d[2]) begin
                miscompares++;
                $display("FAIL drain_idle[%0d]: valid=%b gnt=%b id=%0d data=%h, want 0 0000 2 %h",
                         c, out_valid, gnt, out_id, out_data, ~d[2]);
            end
            tick();
        end
        out_ready = 1'b0;
        req = 4'b0001;
        #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL drain_regrant: gnt=%b, want 0001", gnt);
        end
        tick();
        req = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== ~d[0]) begin
            miscompares++;
            $display("FAIL drain_regrant_out: valid=%b id=%0d data=%h, want 1 0 %h", out_valid, out_id, out_data, ~d[0]);
        end
    endtask

`ifdef NOTER_ARB_COUNT_EN
    task automatic test_count();
        do_reset();
        vectors++;
        if (done_count !== 16'd0) begin
            miscompares++;
            $display("FAIL count_reset: done_count=%0d, want 0", done_count);
        end
        req       = 4'b1111;
        out_ready = 1'b1;
        // first edge only grants; each later edge accepts one transfer
        repeat (70001) @(posedge clk);
        @(negedge clk);
        req = 4'b0000;
        vectors++;
        if (done_count !== 16'd4464) begin
            miscompares++;
            $display("FAIL count_wrap: done_count=%0d, want 4464", done_count);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = '0;
        out_ready   = 1'b0;
        in_data     = '0;
        @(negedge clk);
        test_reset();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_drain();
`ifdef NOTER_ARB_COUNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
